tlb_request_arbiter: RTL and testbench
======================================

# tlb_request_arbiter

Shares the single TLB lookup port between the three translation requesters: code fetch (prefetch control), data read and data write. It arbitrates with fixed priority and a code-starvation guard, then latches the winning request and holds it on the TLB port until the TLB responds. It routes the response back to the winner only. A code request withdrawn by prefetch reset is drained: its response is absorbed and never delivered.

## Interface
- CODE_STARVE_LIMIT, 4: consecutive data grants, while code is pending, after which code wins the next arbitration.
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- pr_reset  input  1  prefetch flush; cancels any pending or in-flight code request.
- tlbcoderequest_do / _address / _su  input  1/32/1  code request.
- tlbcode_do  output  1  code response pulse.
- tlbcode_linear, tlbcode_physical  output  32  code response addresses.
- tlbcode_cache_disable  output  1  code response cache-disable flag.
- tlbread_do / _address / _su  input  1/32/1  data read request.
- tlbread_done  output  1  read response pulse.
- tlbread_physical  output  32  read physical address.
- tlbread_cache_disable, tlbread_fault  output  1  read response flags.
- tlbwrite_do / _address / _su  input  1/32/1  data write request.
- tlbwrite_done, tlbwrite_physical, tlbwrite_cache_disable, tlbwrite_fault  output  1/32/1/1  write response.
- tlb_req_do  output  1  request to TLB; held until tlb_resp_done.
- tlb_req_type  output  2  request type: 0 code, 1 read, 2 write.
- tlb_req_address  output  32  latched linear address.
- tlb_req_su  output  1  latched supervisor/user flag.
- tlb_resp_done  input  1  TLB response pulse.
- tlb_resp_physical  input  32  TLB physical address.
- tlb_resp_cache_disable, tlb_resp_fault  input  1  TLB response flags.

## Operation
- States: IDLE, BUSY, DRAIN. Registers: owner[1:0], latched address/su, starve counter (3 bits, saturating).
- IDLE arbitration:
  - Eligible requesters: write if tlbwrite_do; read if tlbread_do; code if tlbcoderequest_do && ~pr_reset.
  - Priority: write > read > code.
  - Code wins outright if it is eligible and starve counter == CODE_STARVE_LIMIT.
  - On a grant: latch address/su/type, set tlb_req_do, go to BUSY.
- Starve counter:
  - +1 on each data grant while code is eligible.
  - Cleared on a code grant.
  - Cleared when no code request is pending in IDLE.
- BUSY:
  - tlb_req_* are held stable.
  - On tlb_resp_done: pulse the owner's done/do for exactly that cycle with the response fields (combinational pass-through), clear tlb_req_do, go to IDLE.
  - tlbcode_linear returns the latched address.
- Code withdrawal: if owner == code and (pr_reset || ~tlbcoderequest_do) in BUSY, go to DRAIN. tlb_req_do stays high; the TLB contract forbids abandoning a lookup.
- DRAIN:
  - On tlb_resp_done: clear tlb_req_do, go to IDLE.
  - No tlbcode_do pulse is generated; the fault is discarded.
  - If pr_reset and tlb_resp_done occur in the same BUSY cycle, the response is also discarded and the block returns to IDLE.
- Read/write requesters hold do until their done pulse. Dropping do early is a protocol violation; the arbiter completes the lookup regardless.
- Response outputs that are not addressed stay 0. The physical/flag buses read 0 whenever their done/do is 0.
- Reset values: all outputs 0, state IDLE, owner 0, latched regs 0, counter 0.

## Timing
- Request-to-TLB latency is 1 cycle: a request seen in IDLE at cycle N gives tlb_req_do high at N+1.
- Response is 0-cycle: the done pulse appears in the same cycle as tlb_resp_done.
- Back-to-back: the cycle after tlb_resp_done is IDLE (arbitration), so the next tlb_req_do rises 2 cycles after the previous tlb_resp_done. Maximum throughput is one lookup per TLB latency + 2.
- A requester sampled in the same cycle as its done pulse is not re-granted until the following IDLE cycle.

## Structure
- Shared package: the state encodings and the request type constants (code 0, read 1, write 2).
- CODE_STARVE_LIMIT stays a module parameter (legal range 1..7).
- One sub-module: tlb_request_prio, a combinational 3-way priority select with the starvation override, outputting a one-hot grant.
- Expected size: about 200 lines.

## Test plan
- Code-only request, address 0x0040_1234, TLB responds 3 cycles after tlb_req_do with physical 0x0080_1234 -> tlb_req_do rises 1 cycle after the request; tlbcode_do is a single pulse with linear 0x0040_1234, physical 0x0080_1234; no read/write done.
- Write, read and code asserted in the same cycle -> grant order is write, read, code; each tlb_req_type matches (2, 1, 0); each done goes only to its owner.
- Code held continuously while read/write alternate back-to-back -> the 5th grant goes to code (LIMIT=4); the counter is 0 afterwards.
- pr_reset pulsed while code is in BUSY, TLB responds 2 cycles later with fault=1 -> tlb_req_do stays high until the response; no tlbcode_do pulse; IDLE on the next cycle; a pending read is granted immediately after.
- Read with tlb_resp_fault=1 -> tlbread_done=1 and tlbread_fault=1 for one cycle; the write requester is untouched.
- rst_n asserted mid-BUSY -> all outputs 0 asynchronously; after release, the pending requester is re-arbitrated from IDLE with its address re-latched.

Source files
------------

// File: rtl/tlb_request_arbiter_pkg.sv
// Shared definitions for the TLB request arbiter.
//   - arb_state_t : arbiter FSM states (idle / busy / drain)
//   - REQ_*       : request type codes driven on tlb_req_type
//   - grant_to_type: maps a one-hot grant vector {write, read, code} to a type code
package tlb_request_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_CODE  = 2'd0;
    localparam logic [1:0] REQ_READ  = 2'd1;
    localparam logic [1:0] REQ_WRITE = 2'd2;

    // Grant vector bit order: [2] write, [1] read, [0] code.
    function automatic logic [1:0] grant_to_type(input logic [2:0] grant);
        logic [1:0] req_type;
        case (grant)
            3'b100:  req_type = REQ_WRITE;
            3'b010:  req_type = REQ_READ;
            3'b001:  req_type = REQ_CODE;
            default: req_type = REQ_CODE;
        endcase
        return req_type;
    endfunction

endpackage

// File: rtl/tlb_request_arbiter_prio.sv
// Combinational 3-way priority select for the TLB port.
// Ports:
//   code_eligible / read_eligible / write_eligible : qualified requests
//   starve_hit : code has been passed over the limit number of times
//   grant      : one-hot {write, read, code}, all-zero when nothing is eligible
module tlb_request_prio (
    input  logic       code_eligible,
    input  logic       read_eligible,
    input  logic       write_eligible,
    input  logic       starve_hit,
    output logic [2:0] grant
);

    // Fixed priority write > read > code, with the starvation override on top.
    always_comb begin
        grant = 3'b000;
        if (code_eligible && starve_hit) begin
            grant = 3'b001;
        end else if (write_eligible) begin
            grant = 3'b100;
        end else if (read_eligible) begin
            grant = 3'b010;
        end else if (code_eligible) begin
            grant = 3'b001;
        end else begin
            grant = 3'b000;
        end
    end

endmodule

// File: rtl/tlb_request_arbiter.sv
// Shares the single TLB lookup port between code fetch, data read and data
// write. Arbitrates in IDLE, holds the latched request on the TLB port until
// tlb_resp_done, and routes the response (same cycle) to the winner only.
// A code lookup withdrawn by pr_reset (or by the prefetcher dropping its
// request) is drained: the TLB still completes it, the result is discarded.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pr_reset                   : prefetch flush, cancels code requests
//   tlbcoderequest_* / tlbcode_*   : code requester and its response
//   tlbread_* / tlbwrite_*     : data read / write requesters and responses
//   tlb_req_*                  : latched request towards the TLB
//   tlb_resp_*                 : TLB response
module tlb_request_arbiter
    import tlb_request_arbiter_pkg::*;
#(
    parameter int CODE_STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pr_reset,
    input  logic        tlbcoderequest_do,
    input  logic [31:0] tlbcoderequest_address,
    input  logic        tlbcoderequest_su,
    output logic        tlbcode_do,
    output logic [31:0] tlbcode_linear,
    output logic [31:0] tlbcode_physical,
    output logic        tlbcode_cache_disable,
    input  logic        tlbread_do,
    input  logic [31:0] tlbread_address,
    input  logic        tlbread_su,
    output logic        tlbread_done,
    output logic [31:0] tlbread_physical,
    output logic        tlbread_cache_disable,
    output logic        tlbread_fault,
    input  logic        tlbwrite_do,
    input  logic [31:0] tlbwrite_address,
    input  logic        tlbwrite_su,
    output logic        tlbwrite_done,
    output logic [31:0] tlbwrite_physical,
    output logic        tlbwrite_cache_disable,
    output logic        tlbwrite_fault,
    output logic        tlb_req_do,
    output logic [1:0]  tlb_req_type,
    output logic [31:0] tlb_req_address,
    output logic        tlb_req_su,
    input  logic        tlb_resp_done,
    input  logic [31:0] tlb_resp_physical,
    input  logic        tlb_resp_cache_disable,
    input  logic        tlb_resp_fault
);

    localparam logic [2:0] STARVE_LIMIT_C = 3'(CODE_STARVE_LIMIT);

    arb_state_t  state_r;
    logic [1:0]  owner_r;
    logic [31:0] addr_r;
    logic        su_r;
    logic        req_do_r;
    logic [2:0]  starve_r;

    logic        code_eligible_s;
    logic        starve_hit_s;
    logic [2:0]  grant_s;
    logic [31:0] sel_addr_s;
    logic        sel_su_s;
    logic        code_withdraw_s;
    logic        deliver_s;

    assign code_eligible_s = tlbcoderequest_do & ~pr_reset;
    assign starve_hit_s    = (starve_r == STARVE_LIMIT_C);
    // A code owner that flushes or drops its request no longer wants the result.
    assign code_withdraw_s = (owner_r == REQ_CODE) & (pr_reset | ~tlbcoderequest_do);
    assign deliver_s       = (state_r == ST_BUSY) & tlb_resp_done & ~code_withdraw_s;

    tlb_request_prio u_prio (
        .code_eligible  (code_eligible_s),
        .read_eligible  (tlbread_do),
        .write_eligible (tlbwrite_do),
        .starve_hit     (starve_hit_s),
        .grant          (grant_s)
    );

    // Address/su of the arbitration winner, latched on the grant.
    always_comb begin
        sel_addr_s = 32'd0;
        sel_su_s   = 1'b0;
        case (grant_s)
            3'b100: begin
                sel_addr_s = tlbwrite_address;
                sel_su_s   = tlbwrite_su;
            end
            3'b010: begin
                sel_addr_s = tlbread_address;
                sel_su_s   = tlbread_su;
            end
            3'b001: begin
                sel_addr_s = tlbcoderequest_address;
                sel_su_s   = tlbcoderequest_su;
            end
            default: begin
                sel_addr_s = 32'd0;
                sel_su_s   = 1'b0;
            end
        endcase
    end

    // Arbiter FSM, latched request and code starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= 2'd0;
            addr_r   <= 32'd0;
            su_r     <= 1'b0;
            req_do_r <= 1'b0;
            starve_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|grant_s) begin
                        owner_r  <= grant_to_type(grant_s);
                        addr_r   <= sel_addr_s;
                        su_r     <= sel_su_s;
                        req_do_r <= 1'b1;
                        state_r  <= ST_BUSY;
                    end else begin
                        req_do_r <= 1'b0;
                    end
                    if (!code_eligible_s || grant_s[0]) begin
                        starve_r <= 3'd0;
                    end else if ((|grant_s[2:1]) && (starve_r != 3'd7)) begin
                        starve_r <= starve_r + 3'd1;
                    end else begin
                        starve_r <= starve_r;
                    end
                end
                ST_BUSY: begin
                    // The lookup is never abandoned; a withdrawn code lookup
                    // keeps tlb_req_do high until the TLB answers.
                    if (tlb_resp_done) begin
                        req_do_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (code_withdraw_s) begin
                        state_r  <= ST_DRAIN;
                    end else begin
                        state_r  <= ST_BUSY;
                    end
                end
                ST_DRAIN: begin
                    if (tlb_resp_done) begin
                        req_do_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_DRAIN;
                    end
                end
                default: begin
                    req_do_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tlb_req_do      = req_do_r;
    assign tlb_req_type    = owner_r;
    assign tlb_req_address = addr_r;
    assign tlb_req_su      = su_r;

    // Same-cycle response routing; buses of non-addressed requesters read 0.
    always_comb begin
        tlbcode_do             = 1'b0;
        tlbcode_linear         = 32'd0;
        tlbcode_physical       = 32'd0;
        tlbcode_cache_disable  = 1'b0;
        tlbread_done           = 1'b0;
        tlbread_physical       = 32'd0;
        tlbread_cache_disable  = 1'b0;
        tlbread_fault          = 1'b0;
        tlbwrite_done          = 1'b0;
        tlbwrite_physical      = 32'd0;
        tlbwrite_cache_disable = 1'b0;
        tlbwrite_fault         = 1'b0;
        if (deliver_s) begin
            case (owner_r)
                REQ_CODE: begin
                    tlbcode_do            = 1'b1;
                    tlbcode_linear        = addr_r;
                    tlbcode_physical      = tlb_resp_physical;
                    tlbcode_cache_disable = tlb_resp_cache_disable;
                end
                REQ_READ: begin
                    tlbread_done          = 1'b1;
                    tlbread_physical      = tlb_resp_physical;
                    tlbread_cache_disable = tlb_resp_cache_disable;
                    tlbread_fault         = tlb_resp_fault;
                end
                REQ_WRITE: begin
                    tlbwrite_done          = 1'b1;
                    tlbwrite_physical      = tlb_resp_physical;
                    tlbwrite_cache_disable = tlb_resp_cache_disable;
                    tlbwrite_fault         = tlb_resp_fault;
                end
                default: begin
                    tlbcode_do = 1'b0;
                end
            endcase
        end else begin
            tlbcode_do = 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_request_arbiter.sv
// Scoreboard bench for tlb_request_arbiter: expected grants and responses are
// queued as stimulus is driven; a negedge monitor pops and compares them.
module tb_tlb_request_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pr_reset = 1'b0;
    logic        tlbcoderequest_do = 1'b0;
    logic [31:0] tlbcoderequest_address = 32'd0;
    logic        tlbcoderequest_su = 1'b0;
    logic        tlbcode_do;
    logic [31:0] tlbcode_linear;
    logic [31:0] tlbcode_physical;
    logic        tlbcode_cache_disable;
    logic        tlbread_do = 1'b0;
    logic [31:0] tlbread_address = 32'd0;
    logic        tlbread_su = 1'b0;
    logic        tlbread_done;
    logic [31:0] tlbread_physical;
    logic        tlbread_cache_disable;
    logic        tlbread_fault;
    logic        tlbwrite_do = 1'b0;
    logic [31:0] tlbwrite_address = 32'd0;
    logic        tlbwrite_su = 1'b0;
    logic        tlbwrite_done;
    logic [31:0] tlbwrite_physical;
    logic        tlbwrite_cache_disable;
    logic        tlbwrite_fault;
    logic        tlb_req_do;
    logic [1:0]  tlb_req_type;
    logic [31:0] tlb_req_address;
    logic        tlb_req_su;
    logic        tlb_resp_done = 1'b0;
    // Idle response fields carry junk so ungated routing is visible.
    logic [31:0] tlb_resp_physical = 32'hdead_beef;
    logic        tlb_resp_cache_disable = 1'b1;
    logic        tlb_resp_fault = 1'b1;

    tlb_request_arbiter #(.CODE_STARVE_LIMIT(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pr_reset               (pr_reset),
        .tlbcoderequest_do      (tlbcoderequest_do),
        .tlbcoderequest_address (tlbcoderequest_address),
        .tlbcoderequest_su      (tlbcoderequest_su),
        .tlbcode_do             (tlbcode_do),
        .tlbcode_linear         (tlbcode_linear),
        .tlbcode_physical       (tlbcode_physical),
        .tlbcode_cache_disable  (tlbcode_cache_disable),
        .tlbread_do             (tlbread_do),
        .tlbread_address        (tlbread_address),
        .tlbread_su             (tlbread_su),
        .tlbread_done           (tlbread_done),
        .tlbread_physical       (tlbread_physical),
        .tlbread_cache_disable  (tlbread_cache_disable),
        .tlbread_fault          (tlbread_fault),
        .tlbwrite_do            (tlbwrite_do),
        .tlbwrite_address       (tlbwrite_address),
        .tlbwrite_su            (tlbwrite_su),
        .tlbwrite_done          (tlbwrite_done),
        .tlbwrite_physical      (tlbwrite_physical),
        .tlbwrite_cache_disable (tlbwrite_cache_disable),
        .tlbwrite_fault         (tlbwrite_fault),
        .tlb_req_do             (tlb_req_do),
        .tlb_req_type           (tlb_req_type),
        .tlb_req_address        (tlb_req_address),
        .tlb_req_su             (tlb_req_su),
        .tlb_resp_done          (tlb_resp_done),
        .tlb_resp_physical      (tlb_resp_physical),
        .tlb_resp_cache_disable (tlb_resp_cache_disable),
        .tlb_resp_fault         (tlb_resp_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  req_type;
        logic [31:0] addr;
        logic        su;
    } grant_t;

    typedef struct packed {
        logic [2:0]  dones;   // {code, read, write}
        logic [31:0] lin;
        logic [31:0] phys;
        logic        cd;
        logic        fault;
    } resp_t;

    grant_t exp_grant_q[$];
    resp_t  exp_resp_q[$];
    int     chk_cnt = 0;
    int     pass_cnt = 0;
    logic   prev_req_do_r = 1'b0;

    logic [135:0] resp_bus_s;
    assign resp_bus_s = {tlbcode_do, tlbcode_linear, tlbcode_physical, tlbcode_cache_disable,
                         tlbread_done, tlbread_physical, tlbread_cache_disable, tlbread_fault,
                         tlbwrite_done, tlbwrite_physical, tlbwrite_cache_disable, tlbwrite_fault};

    task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [135:0] exp_bus(input resp_t e);
        logic [65:0] c;
        logic [34:0] r;
        logic [34:0] w;
        c = e.dones[2] ? {1'b1, e.lin, e.phys, e.cd} : 66'd0;
        r = e.dones[1] ? {1'b1, e.phys, e.cd, e.fault} : 35'd0;
        w = e.dones[0] ? {1'b1, e.phys, e.cd, e.fault} : 35'd0;
        return {c, r, w};
    endfunction

    // Monitor: new grants and TLB response cycles are compared to the scoreboard.
    always @(negedge clk) begin
        grant_t g;
        resp_t  e;
        if (tlb_req_do && !prev_req_do_r) begin
            if (exp_grant_q.size() == 0) begin
                check_val("grant_unexpected", 160'(1), 160'(0));
            end else begin
                g = exp_grant_q.pop_front();
                check_val("grant", 160'({tlb_req_type, tlb_req_address, tlb_req_su}), 160'(g));
            end
        end
        prev_req_do_r = tlb_req_do;
        if (tlb_resp_done) begin
            if (exp_resp_q.size() == 0) begin
                check_val("resp_unexpected", 160'(1), 160'(0));
            end else begin
                e = exp_resp_q.pop_front();
                check_val("resp", 160'(resp_bus_s), 160'(exp_bus(e)));
            end
        end else begin
            check_val("resp_idle_zero", 160'(resp_bus_s), 160'(0));
        end
    end

    task automatic push_grant(input logic [1:0] t, input logic [31:0] a, input logic s);
        grant_t g;
        g.req_type = t;
        g.addr     = a;
        g.su       = s;
        exp_grant_q.push_back(g);
    endtask

    // Called just after a posedge: one response cycle from the TLB.
    task automatic respond(input logic [31:0] phys, input logic cd, input logic fault,
                           input logic [2:0] dones, input logic [31:0] lin);
        resp_t e;
        e.dones = dones;
        e.lin   = lin;
        e.phys  = phys;
        e.cd    = cd;
        e.fault = fault;
        exp_resp_q.push_back(e);
        tlb_resp_done          = 1'b1;
        tlb_resp_physical      = phys;
        tlb_resp_cache_disable = cd;
        tlb_resp_fault         = fault;
        @(posedge clk);
        #1;
        tlb_resp_done          = 1'b0;
        tlb_resp_physical      = 32'hdead_beef;
        tlb_resp_cache_disable = 1'b1;
        tlb_resp_fault         = 1'b1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!tlb_req_do && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_seen", 160'(tlb_req_do), 160'(1));
    endtask

    task automatic serve(input int lat, input logic [31:0] phys, input logic cd, input logic fault,
                         input logic [2:0] dones, input logic [31:0] lin);
        wait_req();
        repeat (lat) @(posedge clk);
        #1;
        respond(phys, cd, fault, dones, lin);
    endtask

    initial begin
        // Reset state
        #12;
        check_val("rst_req", 160'({tlb_req_do, tlb_req_type, tlb_req_address, tlb_req_su}), 160'(0));
        check_val("rst_resp", 160'(resp_bus_s), 160'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Code-only request, 1-cycle request latency
        tlbcoderequest_address = 32'h0040_1234;
        tlbcoderequest_su      = 1'b1;
        tlbcoderequest_do      = 1'b1;
        push_grant(2'd0, 32'h0040_1234, 1'b1);
        @(negedge clk);
        check_val("code_lat_pre", 160'(tlb_req_do), 160'(0));
        @(negedge clk);
        check_val("code_lat", 160'(tlb_req_do), 160'(1));
        serve(3, 32'h0080_1234, 1'b0, 1'b0, 3'b100, 32'h0040_1234);
        tlbcoderequest_do = 1'b0;

        // All three together: write, read, code
        tlbwrite_address = 32'h1000_0000; tlbwrite_su = 1'b0; tlbwrite_do = 1'b1;
        tlbread_address  = 32'h2000_0000; tlbread_su  = 1'b1; tlbread_do  = 1'b1;
        tlbcoderequest_address = 32'h3000_0000; tlbcoderequest_su = 1'b0; tlbcoderequest_do = 1'b1;
        push_grant(2'd2, 32'h1000_0000, 1'b0);
        push_grant(2'd1, 32'h2000_0000, 1'b1);
        push_grant(2'd0, 32'h3000_0000, 1'b0);
        serve(2, 32'h1100_0000, 1'b1, 1'b0, 3'b001, 32'd0);
        tlbwrite_do = 1'b0;
        serve(1, 32'h2200_0000, 1'b0, 1'b0, 3'b010, 32'd0);
        tlbread_do = 1'b0;
        serve(2, 32'h3300_0000, 1'b1, 1'b0, 3'b100, 32'h3000_0000);
        tlbcoderequest_do = 1'b0;
        @(posedge clk);
        #1;

        // Starvation guard: code held while write/read alternate
        tlbcoderequest_do = 1'b1;
        tlbwrite_do       = 1'b1;
        push_grant(2'd2, 32'h1000_0000, 1'b0);
        push_grant(2'd1, 32'h2000_0000, 1'b1);
        push_grant(2'd2, 32'h1000_0000, 1'b0);
        push_grant(2'd1, 32'h2000_0000, 1'b1);
        push_grant(2'd0, 32'h3000_0000, 1'b0);
        push_grant(2'd2, 32'h1000_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                serve(1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0, 3'b001, 32'd0);
                tlbwrite_do = 1'b0;
                tlbread_do  = 1'b1;
            end else begin
                serve(1, 32'h4000_0000 + 32'(i), 1'b0, 1'b1, 3'b010, 32'd0);
                tlbread_do  = 1'b0;
                tlbwrite_do = 1'b1;
            end
        end
        serve(1, 32'h5000_0000, 1'b0, 1'b0, 3'b100, 32'h3000_0000);
        serve(1, 32'h5100_0000, 1'b0, 1'b0, 3'b001, 32'd0);
        tlbwrite_do       = 1'b0;
        tlbcoderequest_do = 1'b0;
        @(posedge clk);
        #1;

        // pr_reset while code is in BUSY; pending read follows the drain
        tlbcoderequest_address = 32'h0040_2000;
        tlbcoderequest_su      = 1'b0;
        tlbcoderequest_do      = 1'b1;
        push_grant(2'd0, 32'h0040_2000, 1'b0);
        wait_req();
        @(posedge clk);
        #1;
        pr_reset          = 1'b1;
        tlbcoderequest_do = 1'b0;
        tlbread_address   = 32'h0050_0000;
        tlbread_su        = 1'b1;
        tlbread_do        = 1'b1;
        push_grant(2'd1, 32'h0050_0000, 1'b1);
        @(posedge clk);
        #1;
        pr_reset = 1'b0;
        @(negedge clk);
        check_val("drain_hold", 160'(tlb_req_do), 160'(1));
        @(posedge clk);
        #1;
        respond(32'h0060_0000, 1'b0, 1'b1, 3'b000, 32'd0);
        @(negedge clk);
        check_val("drain_idle", 160'(tlb_req_do), 160'(0));
        @(negedge clk);
        check_val("read_after_drain", 160'({tlb_req_do, tlb_req_type}), 160'({1'b1, 2'd1}));
        // Read with a fault
        serve(2, 32'h0090_0000, 1'b1, 1'b1, 3'b010, 32'd0);
        tlbread_do = 1'b0;
        @(posedge clk);
        #1;

        // pr_reset in the same cycle as the code response
        tlbcoderequest_address = 32'h0040_3000;
        tlbcoderequest_do      = 1'b1;
        push_grant(2'd0, 32'h0040_3000, 1'b0);
        wait_req();
        @(posedge clk);
        #1;
        pr_reset          = 1'b1;
        tlbcoderequest_do = 1'b0;
        respond(32'h0070_0000, 1'b0, 1'b0, 3'b000, 32'd0);
        pr_reset = 1'b0;
        @(negedge clk);
        check_val("same_cycle_idle", 160'(tlb_req_do), 160'(0));
        @(negedge clk);
        check_val("same_cycle_no_regrant", 160'(tlb_req_do), 160'(0));

        // Asynchronous reset mid-BUSY, then re-arbitration
        tlbwrite_address = 32'h0aaa_5550;
        tlbwrite_su      = 1'b1;
        tlbwrite_do      = 1'b1;
        push_grant(2'd2, 32'h0aaa_5550, 1'b1);
        wait_req();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_req", 160'({tlb_req_do, tlb_req_type, tlb_req_address, tlb_req_su}), 160'(0));
        check_val("async_rst_resp", 160'(resp_bus_s), 160'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        push_grant(2'd2, 32'h0aaa_5550, 1'b1);
        serve(1, 32'h0bbb_0000, 1'b1, 1'b0, 3'b001, 32'd0);
        tlbwrite_do = 1'b0;

        repeat (3) @(negedge clk);
        check_val("grant_q_empty", 160'(exp_grant_q.size()), 160'(0));
        check_val("resp_q_empty", 160'(exp_resp_q.size()), 160'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
